life_neighbor_window: RTL and testbench
=======================================

# life_neighbor_window

Frame-buffered neighborhood generator for the Game of Life datapath. It loads one generation of the grid as a serial raster bit stream, then emits every cell in raster order together with its eight neighbor bits (Tl, T, Tr, L, R, Bl, B, Br) and the cell's own state. Its outputs drive the per-cell neighbor-count checkers and the next-state logic. It is the producer side of the neighbor interface those checkers consume.

## Interface
Parameters:
- WIDTH, 16, grid columns (≥3)
- HEIGHT, 16, grid rows (≥3)
- WRAP, 0, boundary mode: 0 = out-of-grid cells read as dead, 1 = toroidal wrap

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_cell is valid this cycle
- in_cell  input  1  cell state, raster order (y=0 row first, x=0..WIDTH-1 within row)
- in_ready  output  1  block accepts input (LOAD state)
- out_valid  output  1  neighborhood outputs valid (SCAN state)
- out_ready  input  1  consumer accepts current neighborhood
- C  output  1  state of cell (out_x, out_y)
- Tl, T, Tr, L, R, Bl, B, Br  output  1 each  neighbors at (x-1,y-1), (x,y-1), (x+1,y-1), (x-1,y), (x+1,y), (x-1,y+1), (x,y+1), (x+1,y+1)
- out_x  output  clog2(WIDTH)  column of current cell
- out_y  output  clog2(HEIGHT)  row of current cell
- out_last  output  1  current cell is (WIDTH-1, HEIGHT-1)

## Operation
- Storage: WIDTH×HEIGHT bit frame buffer, plus a linear index counter idx (0..WIDTH*HEIGHT-1) and x/y counters.
- FSM, two states:
  - LOAD: in_ready=1, out_valid=0. On in_valid&in_ready, write in_cell to buffer[idx] and advance idx/x/y. On the handshake with idx = WIDTH*HEIGHT-1, clear counters and go to SCAN.
  - SCAN: in_ready=0, out_valid=1. C and neighbor outputs are read combinationally from the buffer at (out_x, out_y). On out_valid&out_ready, advance. On the handshake with out_last=1, clear counters and go to LOAD.
- Neighbor coordinates: x±1 and y±1 are computed mod WIDTH and mod HEIGHT when WRAP=1. When WRAP=0, any coordinate outside 0..WIDTH-1 or 0..HEIGHT-1 yields 0.
- x counter wraps WIDTH-1→0 and increments y. The buffer is not cleared between frames; every location is overwritten in LOAD.
- in_valid is ignored in SCAN; out_ready is ignored in LOAD.
- Reset: state=LOAD, idx/x/y=0. Buffer contents are don't-care. Reset mid-LOAD or mid-SCAN discards the partial frame or scan.

## Timing
- Reset values: in_ready=1, out_valid=0, out_x=0, out_y=0, out_last=0 (WIDTH*HEIGHT>1). C and the neighbor outputs are don't-care while out_valid=0.
- Load accepts one bit per cycle when in_valid=1. Gaps in in_valid stall without penalty.
- The cycle after the final load handshake has out_valid=1 for cell (0,0); there is no extra latency.
- Scan emits one cell per cycle when out_ready=1. While out_ready=0, all outputs are held stable.
- The cycle after the out_last handshake has in_ready=1. Minimum frame period is 2·WIDTH·HEIGHT cycles.
- in_ready and out_valid are never high together.

## Test plan
- WIDTH=HEIGHT=4, WRAP=0, all-ones frame -> (0,0): R=B=Br=C=1, Tl=T=Tr=L=Bl=0. (1,1): all eight neighbors=1. (3,3): Tl=T=L=1, the rest 0. Exactly 16 out handshakes, out_last only on the 16th.
- 4×4, WRAP=0, single live cell at (2,1) -> (1,0): Br=1, others 0. (3,2): Tl=1. (2,1): C=1, all neighbors 0. Every other cell: C=0 and all neighbors 0 except the 8 adjacent cells.
- 4×4, WRAP=1, single live cell at (0,0) -> (3,3): Br=1. (3,0): R=1. (0,3): B=1. (1,1): Tl=1. All-ones frame gives all neighbors=1 at every cell.
- Backpressure: out_ready=0 for 3 cycles at cell 5 -> out_x=1, out_y=1 and all outputs constant. The scan then resumes at cell 5 with no skip and no duplicate. in_valid toggled every other cycle during LOAD -> frame identical to a gap-free load.
- Reset asserted for one cycle mid-SCAN at cell 7 -> next cycle in_ready=1, out_valid=0, out_x=out_y=0. A fresh frame then loads and scans correctly.
- Back-to-back frames (blinker, then its rotated phase) -> the second scan reflects only the second frame, and in_ready is low for the full scan.

Source files
------------

// File: rtl/life_neighbor_window.sv
// life_neighbor_window
//   Frame-buffered neighborhood generator for the Game of Life datapath.
//   The block first loads one generation of the grid as a serial raster bit
//   stream. It then emits every cell in raster order together with the
//   cell's own state and its eight neighbor bits.
//
// Parameters
//   WIDTH  : grid columns (>= 3)
//   HEIGHT : grid rows (>= 3)
//   WRAP   : 0 = cells outside the grid read as dead, 1 = toroidal wrap
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_cell carries a valid bit this cycle
//   in_cell   : cell state, raster order (row 0 first, x = 0..WIDTH-1)
//   in_ready  : block is loading and accepts input
//   out_valid : neighborhood outputs are valid (scanning)
//   out_ready : consumer accepts the current neighborhood
//   C         : state of cell (out_x, out_y)
//   Tl..Br    : neighbors (x-1,y-1) (x,y-1) (x+1,y-1) (x-1,y) (x+1,y)
//               (x-1,y+1) (x,y+1) (x+1,y+1)
//   out_x     : column of the current cell
//   out_y     : row of the current cell
//   out_last  : current cell is (WIDTH-1, HEIGHT-1)
module life_neighbor_window #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int WRAP   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_cell,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      C,
    output logic                      Tl,
    output logic                      T,
    output logic                      Tr,
    output logic                      L,
    output logic                      R,
    output logic                      Bl,
    output logic                      B,
    output logic                      Br,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      out_last
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int CELLS = WIDTH * HEIGHT;
    localparam int IW    = $clog2(CELLS);

    localparam logic [XW-1:0] X_MAX   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(HEIGHT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(CELLS - 1);

    typedef enum logic {
        LOAD,
        SCAN
    } state_t;

    state_t          state, state_next;
    logic [XW-1:0]   x, x_next;
    logic [YW-1:0]   y, y_next;
    logic [IW-1:0]   idx, idx_next;
    logic [CELLS-1:0] frame;
    logic            frame_we;

    logic [XW-1:0]   xm, xp;
    logic [YW-1:0]   ym, yp;
    logic            xm_ok, xp_ok, ym_ok, yp_ok;

    function automatic logic cell_at(input logic [CELLS-1:0] fr,
                                     input logic [XW-1:0]    cx,
                                     input logic [YW-1:0]    cy);
        return fr[IW'(32'(cy) * 32'(WIDTH) + 32'(cx))];
    endfunction

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            x     <= '0;
            y     <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
            idx   <= idx_next;
        end
    end

    // Frame buffer has no reset: every location is rewritten each LOAD
    always_ff @(posedge clk) begin
        if (frame_we) begin
            frame[idx] <= in_cell;
        end
    end

    // Next-state, counter advance and handshake outputs
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        idx_next   = idx;
        frame_we   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    frame_we = 1'b1;
                    if (idx == IDX_MAX) begin
                        x_next     = '0;
                        y_next     = '0;
                        idx_next   = '0;
                        state_next = SCAN;
                    end else begin
                        idx_next = idx + IW'(1);
                        if (x == X_MAX) begin
                            x_next = '0;
                            y_next = y + YW'(1);
                        end else begin
                            x_next = x + XW'(1);
                        end
                    end
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (x == X_MAX && y == Y_MAX) begin
                        x_next     = '0;
                        y_next     = '0;
                        idx_next   = '0;
                        state_next = LOAD;
                    end else begin
                        idx_next = idx + IW'(1);
                        if (x == X_MAX) begin
                            x_next = '0;
                            y_next = y + YW'(1);
                        end else begin
                            x_next = x + XW'(1);
                        end
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Neighbor coordinates; the *_ok flags kill out-of-grid reads when not wrapping
    always_comb begin
        xm    = (x == '0)    ? X_MAX : x - XW'(1);
        xp    = (x == X_MAX) ? '0    : x + XW'(1);
        ym    = (y == '0)    ? Y_MAX : y - YW'(1);
        yp    = (y == Y_MAX) ? '0    : y + YW'(1);
        xm_ok = (x != '0)    || (WRAP != 0);
        xp_ok = (x != X_MAX) || (WRAP != 0);
        ym_ok = (y != '0)    || (WRAP != 0);
        yp_ok = (y != Y_MAX) || (WRAP != 0);
    end

    assign C  = cell_at(frame, x, y);
    assign Tl = xm_ok & ym_ok & cell_at(frame, xm, ym);
    assign T  =         ym_ok & cell_at(frame, x,  ym);
    assign Tr = xp_ok & ym_ok & cell_at(frame, xp, ym);
    assign L  = xm_ok &         cell_at(frame, xm, y);
    assign R  = xp_ok &         cell_at(frame, xp, y);
    assign Bl = xm_ok & yp_ok & cell_at(frame, xm, yp);
    assign B  =         yp_ok & cell_at(frame, x,  yp);
    assign Br = xp_ok & yp_ok & cell_at(frame, xp, yp);

    assign out_x    = x;
    assign out_y    = y;
    assign out_last = (state == SCAN) && (x == X_MAX) && (y == Y_MAX);

endmodule

// File: tb/tb_life_neighbor_window.sv
// tb_life_neighbor_window
//   Directed bench for life_neighbor_window on a 4x4 grid. Two instances
//   (WRAP=0 and WRAP=1) share the same stimulus and scan in lockstep.
//   Neighborhood vectors are packed as {C,Tl,T,Tr,L,R,Bl,B,Br}.
module tb_life_neighbor_window;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_cell;
    logic out_ready;

    logic       in_ready0, out_valid0, out_last0;
    logic       c0, tl0, t0, tr0, l0, r0, bl0, b0, br0;
    logic [1:0] out_x0, out_y0;
    logic       in_ready1, out_valid1, out_last1;
    logic       c1, tl1, t1, tr1, l1, r1, bl1, b1, br1;
    logic [1:0] out_x1, out_y1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    life_neighbor_window #(.WIDTH(4), .HEIGHT(4), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cell(in_cell),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
        .C(c0), .Tl(tl0), .T(t0), .Tr(tr0), .L(l0), .R(r0),
        .Bl(bl0), .B(b0), .Br(br0),
        .out_x(out_x0), .out_y(out_y0), .out_last(out_last0)
    );

    life_neighbor_window #(.WIDTH(4), .HEIGHT(4), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cell(in_cell),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .C(c1), .Tl(tl1), .T(t1), .Tr(tr1), .L(l1), .R(r1),
        .Bl(bl1), .B(b1), .Br(br1),
        .out_x(out_x1), .out_y(out_y1), .out_last(out_last1)
    );

    logic [8:0]  nb0, nb1;
    logic [31:0] obs_all;
    logic [13:0] obs_ctl;

    assign nb0 = {c0, tl0, t0, tr0, l0, r0, bl0, b0, br0};
    assign nb1 = {c1, tl1, t1, tr1, l1, r1, bl1, b1, br1};
    assign obs_all = {in_ready0, out_valid0, out_x0, out_y0, out_last0, nb0,
                      in_ready1, out_valid1, out_x1, out_y1, out_last1, nb1};
    assign obs_ctl = {in_ready0, out_valid0, out_x0, out_y0, out_last0,
                      in_ready1, out_valid1, out_x1, out_y1, out_last1};

    // Reference: cell value with dead or wrapped boundary
    function automatic logic ref_cell(input logic [15:0] f, input int wrap,
                                      input int cx, input int cy);
        int xx, yy;
        xx = cx;
        yy = cy;
        if (wrap != 0) begin
            xx = (xx + 4) % 4;
            yy = (yy + 4) % 4;
        end else if (xx < 0 || xx > 3 || yy < 0 || yy > 3) begin
            return 1'b0;
        end
        return f[4'(yy * 4 + xx)];
    endfunction

    function automatic logic [8:0] ref_nb(input logic [15:0] f, input int wrap,
                                          input int cx, input int cy);
        return {ref_cell(f, wrap, cx,     cy),
                ref_cell(f, wrap, cx - 1, cy - 1),
                ref_cell(f, wrap, cx,     cy - 1),
                ref_cell(f, wrap, cx + 1, cy - 1),
                ref_cell(f, wrap, cx - 1, cy),
                ref_cell(f, wrap, cx + 1, cy),
                ref_cell(f, wrap, cx - 1, cy + 1),
                ref_cell(f, wrap, cx,     cy + 1),
                ref_cell(f, wrap, cx + 1, cy + 1)};
    endfunction

    function automatic logic [31:0] exp_cell(input logic [15:0] f, input int i);
        logic [1:0] ex, ey;
        logic       el;
        ex = 2'(i % 4);
        ey = 2'(i / 4);
        el = (i == 15);
        return {1'b0, 1'b1, ex, ey, el, ref_nb(f, 0, i % 4, i / 4),
                1'b0, 1'b1, ex, ey, el, ref_nb(f, 1, i % 4, i / 4)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle/load-state control outputs on both instances
    task automatic check_idle(input string tag);
        check(tag, 32'(obs_ctl), 32'({7'b1000000, 7'b1000000}));
    endtask

    task automatic load_frame(input logic [15:0] f, input bit gaps);
        check_idle("load_start");
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_cell  = ~f[4'(i)];
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_cell  = f[4'(i)];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_cell  = 1'b0;
    endtask

    // Check cells n0..n1-1 against the reference, one handshake per cell
    task automatic scan_cells(input logic [15:0] f, input int n0, input int n1);
        for (int i = n0; i < n1; i++) begin
            check($sformatf("scan_cell%0d", i), obs_all, exp_cell(f, i));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cell   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;

        // All-ones frame: edge and interior neighborhoods
        load_frame(16'hFFFF, 1'b0);
        check("ones_00_nowrap",  32'(nb0), 32'(9'b1_0000_1011));
        check("ones_00_wrap",    32'(nb1), 32'(9'b1_1111_1111));
        scan_cells(16'hFFFF, 0, 5);
        check("ones_11_nowrap",  32'(nb0), 32'(9'b1_1111_1111));
        scan_cells(16'hFFFF, 5, 15);
        check("ones_33_nowrap",  32'(nb0), 32'(9'b1_1101_0000));
        scan_cells(16'hFFFF, 15, 16);
        check_idle("ones_done");

        // Single live cell at (2,1), index 6
        load_frame(16'h0040, 1'b0);
        scan_cells(16'h0040, 0, 1);
        check("single_10_Br",    32'(nb0), 32'(9'b0_0000_0001));
        scan_cells(16'h0040, 1, 6);
        check("single_21_C",     32'(nb0), 32'(9'b1_0000_0000));
        scan_cells(16'h0040, 6, 11);
        check("single_32_Tl",    32'(nb0), 32'(9'b0_1000_0000));
        scan_cells(16'h0040, 11, 16);
        check_idle("single_done");

        // Live cell at (0,0), loaded with in_valid toggling every other cycle
        load_frame(16'h0001, 1'b1);
        check("wrap_00_C",       32'(nb1), 32'(9'b1_0000_0000));
        scan_cells(16'h0001, 0, 3);
        check("wrap_30_R",       32'(nb1), 32'(9'b0_0000_1000));
        scan_cells(16'h0001, 3, 5);
        check("wrap_11_Tl",      32'(nb1), 32'(9'b0_1000_0000));
        scan_cells(16'h0001, 5, 12);
        check("wrap_03_B",       32'(nb1), 32'(9'b0_0000_0010));
        scan_cells(16'h0001, 12, 15);
        check("wrap_33_Br",      32'(nb1), 32'(9'b0_0000_0001));
        check("nowrap_33_none",  32'(nb0), 32'(9'b0_0000_0000));
        scan_cells(16'h0001, 15, 16);
        check_idle("wrap_done");

        // Backpressure at cell 5; in_valid pulsed meanwhile must be ignored
        load_frame(16'hA5C3, 1'b0);
        scan_cells(16'hA5C3, 0, 5);
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_cell   = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            check($sformatf("hold_cycle%0d", k), obs_all, exp_cell(16'hA5C3, 5));
        end
        in_valid = 1'b0;
        in_cell  = 1'b0;
        scan_cells(16'hA5C3, 5, 16);
        check_idle("hold_done");

        // Reset mid-scan at cell 7, then a fresh frame
        load_frame(16'h3C96, 1'b0);
        scan_cells(16'h3C96, 0, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_midscan");
        load_frame(16'h6B1D, 1'b0);
        scan_cells(16'h6B1D, 0, 16);
        check_idle("after_reset_done");

        // Back-to-back blinker phases
        load_frame(16'h0070, 1'b0);
        scan_cells(16'h0070, 0, 16);
        load_frame(16'h0222, 1'b0);
        scan_cells(16'h0222, 0, 5);
        check("blinker2_11",     32'(nb0), 32'(9'b1_0100_0010));
        scan_cells(16'h0222, 5, 16);
        check_idle("blinker_done");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
